// File: rtl/dispatch_queue_if.sv
// Fetch-side handshake and issue-side bus of the dispatch queue.
// The queue takes the slave modport; fetcher/consumers take master.
interface dispatch_queue_if #(
  parameter int XLEN     = 32,
  parameter int OP_W     = 6,
  parameter int ROB_ID_W = 4
);
  logic                fet_valid;
  logic                fet_ready;
  logic [XLEN-1:0]     fet_pc;
  logic                fet_pred_jump;
  logic                fet_is_ls;
  logic                fet_is_jump;
  logic [OP_W-1:0]     fet_optype;
  logic [4:0]          fet_rd;
  logic [4:0]          fet_rs1;
  logic [4:0]          fet_rs2;
  logic [XLEN-1:0]     fet_imm;

  logic                rob_push;
  logic                rename_en;
  logic                ena_rs;
  logic                ena_lsb;
  logic [ROB_ID_W-1:0] out_alias;
  logic [4:0]          out_rd;
  logic [XLEN-1:0]     out_pc;
  logic [OP_W-1:0]     out_optype;
  logic                out_is_jump;
  logic                out_pred_jump;
  logic [ROB_ID_W-1:0] out_q1;
  logic [ROB_ID_W-1:0] out_q2;
  logic [XLEN-1:0]     out_v1;
  logic [XLEN-1:0]     out_v2;
  logic [XLEN-1:0]     out_imm;

  modport slave (
    input  fet_valid, fet_pc, fet_pred_jump, fet_is_ls, fet_is_jump,
           fet_optype, fet_rd, fet_rs1, fet_rs2, fet_imm,
    output fet_ready,
    output rob_push, rename_en, ena_rs, ena_lsb, out_alias, out_rd, out_pc,
           out_optype, out_is_jump, out_pred_jump, out_q1, out_q2, out_v1,
           out_v2, out_imm
  );

  modport master (
    output fet_valid, fet_pc, fet_pred_jump, fet_is_ls, fet_is_jump,
           fet_optype, fet_rd, fet_rs1, fet_rs2, fet_imm,
    input  fet_ready,
    input  rob_push, rename_en, ena_rs, ena_lsb, out_alias, out_rd, out_pc,
           out_optype, out_is_jump, out_pred_jump, out_q1, out_q2, out_v1,
           out_v2, out_imm
  );
endinterface

// File: rtl/dispatch_queue.sv
// FIFO-buffered dispatcher: queues pre-decoded instructions and issues one per
// cycle from the head to ROB and RS/LSB with operands resolved RF -> ROB -> CDB.
module dispatch_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_CDB     = 2,
  parameter int ROB_ID_W    = 4,
  parameter int XLEN        = 32,
  parameter int OP_W        = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        rollback,
  dispatch_queue_if.slave             bus,
  input  logic                        rs_full,
  input  logic                        lsb_full,
  input  logic                        rob_full,
  input  logic [ROB_ID_W-1:0]         rob_alloc_id,
  output logic [4:0]                  rs1_idx,
  output logic [4:0]                  rs2_idx,
  input  logic [ROB_ID_W-1:0]         rf_q1,
  input  logic [ROB_ID_W-1:0]         rf_q2,
  input  logic [XLEN-1:0]             rf_v1,
  input  logic [XLEN-1:0]             rf_v2,
  input  logic                        rob_q1_rdy,
  input  logic                        rob_q2_rdy,
  input  logic [XLEN-1:0]             rob_v1,
  input  logic [XLEN-1:0]             rob_v2,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_alias,
  input  logic [NUM_CDB*XLEN-1:0]     cdb_value
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_jump;
    logic            is_ls;
    logic            is_jump;
    logic [OP_W-1:0] optype;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
  } entry_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] q;
    logic [XLEN-1:0]     v;
  } opnd_t;

  entry_t             mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  entry_t             head_e;
  logic               not_empty;
  logic               unit_full;
  logic               issue;
  logic               enq;
  logic               byp1;
  logic               byp2;
  opnd_t              op1;
  opnd_t              op2;

  // The bypass tag wins over everything; CDB can still resolve any tag left over.
  function automatic opnd_t resolve(
    input logic [4:0]                  rs,
    input logic                        byp,
    input logic [ROB_ID_W-1:0]         byp_q,
    input logic [ROB_ID_W-1:0]         rf_q,
    input logic [XLEN-1:0]             rf_v,
    input logic                        rob_rdy,
    input logic [XLEN-1:0]             rob_v,
    input logic [NUM_CDB-1:0]          cv,
    input logic [NUM_CDB*ROB_ID_W-1:0] ca,
    input logic [NUM_CDB*XLEN-1:0]     cval
  );
    opnd_t r;
    logic  hit;
    r   = '0;
    hit = 1'b0;
    if (rs != 5'd0) begin
      if (byp)              r.q = byp_q;
      else if (rf_q == '0)  r.v = rf_v;
      else if (rob_rdy)     r.v = rob_v;
      else                  r.q = rf_q;
      if (r.q != '0) begin
        for (int unsigned i = 0; i < NUM_CDB; i++) begin
          if (!hit && cv[i] && ca[i*ROB_ID_W +: ROB_ID_W] == r.q) begin
            hit = 1'b1;
            r.v = cval[i*XLEN +: XLEN];
          end
        end
        if (hit) r.q = '0;
      end
    end
    return r;
  endfunction

  // Acceptance looks only at the registered count, never at a same-cycle pop.
  assign bus.fet_ready = (count != CNT_W'(QUEUE_DEPTH));

  always_comb begin
    head_e    = mem[head];
    not_empty = (count != '0);
    unit_full = head_e.is_ls ? lsb_full : rs_full;
    issue     = rdy && !rollback && not_empty && !rob_full && !unit_full;
    enq       = bus.fet_valid && bus.fet_ready && rdy && !rollback;
    rs1_idx   = not_empty ? head_e.rs1 : 5'd0;
    rs2_idx   = not_empty ? head_e.rs2 : 5'd0;
    // rename_en high means last cycle's issue renamed out_rd, not yet in the regfile
    byp1      = bus.rename_en && (bus.out_rd == head_e.rs1);
    byp2      = bus.rename_en && (bus.out_rd == head_e.rs2);
    op1       = resolve(head_e.rs1, byp1, bus.out_alias, rf_q1, rf_v1, rob_q1_rdy,
                        rob_v1, cdb_valid, cdb_alias, cdb_value);
    op2       = resolve(head_e.rs2, byp2, bus.out_alias, rf_q2, rf_v2, rob_q2_rdy,
                        rob_v2, cdb_valid, cdb_alias, cdb_value);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= '{pc:        bus.fet_pc,
                     pred_jump: bus.fet_pred_jump,
                     is_ls:     bus.fet_is_ls,
                     is_jump:   bus.fet_is_jump,
                     optype:    bus.fet_optype,
                     rd:        bus.fet_rd,
                     rs1:       bus.fet_rs1,
                     rs2:       bus.fet_rs2,
                     imm:       bus.fet_imm};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      bus.rob_push      <= 1'b0;
      bus.rename_en     <= 1'b0;
      bus.ena_rs        <= 1'b0;
      bus.ena_lsb       <= 1'b0;
      bus.out_alias     <= '0;
      bus.out_rd        <= '0;
      bus.out_pc        <= '0;
      bus.out_optype    <= '0;
      bus.out_is_jump   <= 1'b0;
      bus.out_pred_jump <= 1'b0;
      bus.out_q1        <= '0;
      bus.out_q2        <= '0;
      bus.out_v1        <= '0;
      bus.out_v2        <= '0;
      bus.out_imm       <= '0;
    end else if (rollback) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      bus.rob_push  <= 1'b0;
      bus.rename_en <= 1'b0;
      bus.ena_rs    <= 1'b0;
      bus.ena_lsb   <= 1'b0;
    end else if (rdy) begin
      if (issue) head <= head + PTR_W'(1);
      if (enq)   tail <= tail + PTR_W'(1);
      case ({enq, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      bus.rob_push  <= issue;
      bus.rename_en <= issue && (head_e.rd != 5'd0);
      bus.ena_rs    <= issue && !head_e.is_ls;
      bus.ena_lsb   <= issue && head_e.is_ls;
      if (issue) begin
        bus.out_alias     <= rob_alloc_id;
        bus.out_rd        <= head_e.rd;
        bus.out_pc        <= head_e.pc;
        bus.out_optype    <= head_e.optype;
        bus.out_is_jump   <= head_e.is_jump;
        bus.out_pred_jump <= head_e.pred_jump;
        bus.out_q1        <= op1.q;
        bus.out_q2        <= op2.q;
        bus.out_v1        <= op1.v;
        bus.out_v2        <= op2.v;
        bus.out_imm       <= head_e.imm;
      end
    end else begin
      bus.rob_push  <= 1'b0;
      bus.rename_en <= 1'b0;
      bus.ena_rs    <= 1'b0;
      bus.ena_lsb   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed scoreboard bench for dispatch_queue: stimulus pushes expected issues,
// a negedge monitor pops and compares whenever rob_push is seen.
module tb_dispatch_queue;
  localparam int XLEN = 32;
  localparam int OP_W = 6;
  localparam int RW   = 4;
  localparam int NC   = 2;
  localparam int QD   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              rollback;
  logic              rs_full;
  logic              lsb_full;
  logic              rob_full;
  logic [RW-1:0]     rob_alloc_id;
  logic [4:0]        rs1_idx;
  logic [4:0]        rs2_idx;
  logic [RW-1:0]     rf_q1;
  logic [RW-1:0]     rf_q2;
  logic [XLEN-1:0]   rf_v1;
  logic [XLEN-1:0]   rf_v2;
  logic              rob_q1_rdy;
  logic              rob_q2_rdy;
  logic [XLEN-1:0]   rob_v1;
  logic [XLEN-1:0]   rob_v2;
  logic [NC-1:0]     cdb_valid;
  logic [NC*RW-1:0]  cdb_alias;
  logic [NC*XLEN-1:0] cdb_value;

  always #5 clk = ~clk;

  dispatch_queue_if #(.XLEN(XLEN), .OP_W(OP_W), .ROB_ID_W(RW)) bus ();

  dispatch_queue #(
    .QUEUE_DEPTH(QD), .NUM_CDB(NC), .ROB_ID_W(RW), .XLEN(XLEN), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus.slave),
    .rs_full(rs_full), .lsb_full(lsb_full), .rob_full(rob_full),
    .rob_alloc_id(rob_alloc_id), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rf_q1(rf_q1), .rf_q2(rf_q2), .rf_v1(rf_v1), .rf_v2(rf_v2),
    .rob_q1_rdy(rob_q1_rdy), .rob_q2_rdy(rob_q2_rdy),
    .rob_v1(rob_v1), .rob_v2(rob_v2),
    .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_value(cdb_value)
  );

  typedef struct {
    logic [RW-1:0]   aid;
    logic [4:0]      rd;
    logic [31:0]     pc;
    logic [5:0]      optype;
    logic            is_jump;
    logic            pred_jump;
    logic            is_ls;
    logic            rename;
    logic [RW-1:0]   q1;
    logic [31:0]     v1;
    logic [RW-1:0]   q2;
    logic [31:0]     v2;
    logic [31:0]     imm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Instruction fields other than rd/rs derive from pc so each entry is distinct.
  task automatic drive(input logic [31:0] pc, input logic ls, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.fet_valid     = 1'b1;
    bus.fet_pc        = pc;
    bus.fet_is_ls     = ls;
    bus.fet_rd        = rd;
    bus.fet_rs1       = rs1;
    bus.fet_rs2       = rs2;
    bus.fet_imm       = pc ^ 32'h5A5A_0000;
    bus.fet_optype    = pc[7:2];
    bus.fet_is_jump   = pc[4];
    bus.fet_pred_jump = pc[5];
  endtask

  task automatic expect_issue(input logic [31:0] pc, input logic ls, input logic [4:0] rd,
                              input logic [RW-1:0] aid,
                              input logic [RW-1:0] q1, input logic [31:0] v1,
                              input logic [RW-1:0] q2, input logic [31:0] v2);
    exp_t e;
    e.aid = aid;  e.rd = rd;  e.pc = pc;  e.is_ls = ls;  e.rename = (rd != 5'd0);
    e.optype = pc[7:2];  e.is_jump = pc[4];  e.pred_jump = pc[5];
    e.imm = pc ^ 32'h5A5A_0000;
    e.q1 = q1;  e.v1 = v1;  e.q2 = q2;  e.v2 = v2;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.fet_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.rob_push) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual_pc=%0h required=none", bus.out_pc);
      end else begin
        e = sb.pop_front();
        chk("alias",     64'(bus.out_alias),     64'(e.aid));
        chk("pc",        64'(bus.out_pc),        64'(e.pc));
        chk("rd",        64'(bus.out_rd),        64'(e.rd));
        chk("optype",    64'(bus.out_optype),    64'(e.optype));
        chk("is_jump",   64'(bus.out_is_jump),   64'(e.is_jump));
        chk("pred_jump", 64'(bus.out_pred_jump), 64'(e.pred_jump));
        chk("imm",       64'(bus.out_imm),       64'(e.imm));
        chk("q1",        64'(bus.out_q1),        64'(e.q1));
        chk("v1",        64'(bus.out_v1),        64'(e.v1));
        chk("q2",        64'(bus.out_q2),        64'(e.q2));
        chk("v2",        64'(bus.out_v2),        64'(e.v2));
        chk("rename_en", 64'(bus.rename_en),     64'(e.rename));
        chk("ena_lsb",   64'(bus.ena_lsb),       64'(e.is_ls));
        chk("ena_rs",    64'(bus.ena_rs),        64'(!e.is_ls));
      end
    end
  end

  initial begin
    rst = 1'b1;  rdy = 1'b1;  rollback = 1'b0;
    rs_full = 1'b0;  lsb_full = 1'b0;  rob_full = 1'b0;  rob_alloc_id = '0;
    rf_q1 = '0;  rf_q2 = '0;  rf_v1 = 32'h100;  rf_v2 = 32'h200;
    rob_q1_rdy = 1'b0;  rob_q2_rdy = 1'b0;  rob_v1 = '0;  rob_v2 = '0;
    cdb_valid = '0;  cdb_alias = '0;  cdb_value = '0;
    drive(32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle();

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_fet_ready", 64'(bus.fet_ready), 64'd1);
    chk("rst_rob_push",  64'(bus.rob_push),  64'd0);
    chk("rst_rename_en", 64'(bus.rename_en), 64'd0);
    chk("rst_ena_rs",    64'(bus.ena_rs),    64'd0);
    chk("rst_ena_lsb",   64'(bus.ena_lsb),   64'd0);
    chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
    chk("rst_out_alias", 64'(bus.out_alias), 64'd0);
    chk("rst_out_v1",    64'(bus.out_v1),    64'd0);

    // three back-to-back entries, each issuing one cycle after enqueue
    drive(32'h1000, 1'b0, 5'd1, 5'd2, 5'd3);
    expect_issue(32'h1000, 1'b0, 5'd1, 4'd5, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    chk("head_rs1_idx", 64'(rs1_idx), 64'd2);
    drive(32'h1014, 1'b0, 5'd4, 5'd2, 5'd0);
    expect_issue(32'h1014, 1'b0, 5'd4, 4'd6, '0, 32'h100, '0, 32'h0);
    rob_alloc_id = 4'd5;
    @(negedge clk);
    chk("b2b_push_a", 64'(bus.rob_push), 64'd1);
    drive(32'h1028, 1'b0, 5'd6, 5'd3, 5'd5);
    expect_issue(32'h1028, 1'b0, 5'd6, 4'd7, '0, 32'h100, '0, 32'h200);
    rob_alloc_id = 4'd6;
    @(negedge clk);
    chk("b2b_push_b", 64'(bus.rob_push), 64'd1);
    idle();
    rob_alloc_id = 4'd7;
    @(negedge clk);
    chk("b2b_push_c", 64'(bus.rob_push), 64'd1);
    @(negedge clk);
    chk("b2b_push_end", 64'(bus.rob_push), 64'd0);

    // fill to depth while RS is full, then drain in order
    rs_full = 1'b1;
    drive(32'h2000, 1'b0, 5'd7, 5'd1, 5'd2);
    expect_issue(32'h2000, 1'b0, 5'd7, 4'd8, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    drive(32'h2004, 1'b0, 5'd8, 5'd1, 5'd2);
    expect_issue(32'h2004, 1'b0, 5'd8, 4'd9, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    drive(32'h2008, 1'b0, 5'd10, 5'd1, 5'd2);
    expect_issue(32'h2008, 1'b0, 5'd10, 4'd10, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    drive(32'h200C, 1'b0, 5'd11, 5'd1, 5'd2);
    expect_issue(32'h200C, 1'b0, 5'd11, 4'd11, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    chk("full_fet_ready", 64'(bus.fet_ready), 64'd0);
    chk("full_no_issue",  64'(bus.rob_push),  64'd0);
    drive(32'h2FF0, 1'b0, 5'd12, 5'd1, 5'd2);
    @(negedge clk);
    chk("full_reject_ready", 64'(bus.fet_ready), 64'd0);
    idle();
    rs_full = 1'b0;
    rob_alloc_id = 4'd8;
    @(negedge clk);
    chk("ready_after_pop", 64'(bus.fet_ready), 64'd1);
    rob_alloc_id = 4'd9;
    @(negedge clk);
    rob_alloc_id = 4'd10;
    @(negedge clk);
    rob_alloc_id = 4'd11;
    @(negedge clk);
    @(negedge clk);
    chk("drain_end", 64'(bus.rob_push), 64'd0);

    // back-to-back rename hazard on x5
    drive(32'h3000, 1'b0, 5'd5, 5'd1, 5'd2);
    expect_issue(32'h3000, 1'b0, 5'd5, 4'd3, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    drive(32'h3004, 1'b0, 5'd6, 5'd5, 5'd2);
    expect_issue(32'h3004, 1'b0, 5'd6, 4'd4, 4'd3, 32'h0, '0, 32'h200);
    rob_alloc_id = 4'd3;
    @(negedge clk);
    chk("hazard_rs1_idx", 64'(rs1_idx), 64'd5);
    idle();
    rob_alloc_id = 4'd4;
    @(negedge clk);
    @(negedge clk);

    // ROB-ready operand 1, CDB channel 1 forward on operand 2
    drive(32'h4000, 1'b0, 5'd9, 5'd1, 5'd7);
    expect_issue(32'h4000, 1'b0, 5'd9, 4'd12, '0, 32'hBEEF, '0, 32'hDEAD);
    rf_q1 = 4'd2;  rob_q1_rdy = 1'b1;  rob_v1 = 32'hBEEF;
    rf_q2 = 4'd7;  rob_q2_rdy = 1'b0;
    cdb_valid = 2'b10;  cdb_alias = {4'd7, 4'd2};  cdb_value = {32'hDEAD, 32'h1111};
    rob_alloc_id = 4'd0;
    @(negedge clk);
    idle();
    rob_alloc_id = 4'd12;
    @(negedge clk);

    // unresolved tag on operand 1; both channels match operand 2, lowest wins
    drive(32'h4010, 1'b0, 5'd10, 5'd3, 5'd3);
    expect_issue(32'h4010, 1'b0, 5'd10, 4'd13, 4'd9, 32'h0, '0, 32'hAAAA);
    rf_q1 = 4'd9;  rob_q1_rdy = 1'b0;
    rf_q2 = 4'd5;  rob_q2_rdy = 1'b0;
    cdb_valid = 2'b11;  cdb_alias = {4'd5, 4'd5};  cdb_value = {32'hBBBB, 32'hAAAA};
    rob_alloc_id = 4'd0;
    @(negedge clk);
    idle();
    rob_alloc_id = 4'd13;
    @(negedge clk);
    rf_q1 = '0;  rf_q2 = '0;  rob_q1_rdy = 1'b0;  rob_v1 = '0;
    cdb_valid = '0;  cdb_alias = '0;  cdb_value = '0;

    // load blocked by full LSB while RS is free
    lsb_full = 1'b1;
    drive(32'h5000, 1'b1, 5'd10, 5'd1, 5'd2);
    expect_issue(32'h5000, 1'b1, 5'd10, 4'd14, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("lsb_block_push", 64'(bus.rob_push), 64'd0);
    chk("lsb_block_ena",  64'(bus.ena_lsb),  64'd0);
    @(negedge clk);
    chk("lsb_block_push2", 64'(bus.rob_push), 64'd0);
    lsb_full = 1'b0;
    rob_alloc_id = 4'd14;
    @(negedge clk);
    chk("lsb_release_push", 64'(bus.rob_push), 64'd1);
    @(negedge clk);

    // rollback with 3 queued, then a paused cycle; fetch attempts must be dropped
    rs_full = 1'b1;
    drive(32'h6000, 1'b0, 5'd1, 5'd1, 5'd2);
    @(negedge clk);
    drive(32'h6004, 1'b0, 5'd2, 5'd1, 5'd2);
    @(negedge clk);
    drive(32'h6008, 1'b0, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    rollback = 1'b1;
    rs_full = 1'b0;
    drive(32'h6F00, 1'b0, 5'd4, 5'd1, 5'd2);
    @(negedge clk);
    chk("rollback_push", 64'(bus.rob_push), 64'd0);
    rollback = 1'b0;
    rdy = 1'b0;
    drive(32'h6F04, 1'b0, 5'd4, 5'd1, 5'd2);
    @(negedge clk);
    chk("pause_push",  64'(bus.rob_push),  64'd0);
    chk("pause_ready", 64'(bus.fet_ready), 64'd1);
    rdy = 1'b1;
    idle();
    @(negedge clk);
    chk("post_rollback_push", 64'(bus.rob_push), 64'd0);
    @(negedge clk);
    chk("empty_after_rollback", 64'(bus.rob_push), 64'd0);

    // rd = 0 instruction: pushes to ROB without renaming
    drive(32'h7000, 1'b0, 5'd0, 5'd0, 5'd0);
    expect_issue(32'h7000, 1'b0, 5'd0, 4'd15, '0, 32'h0, '0, 32'h0);
    rob_alloc_id = 4'd0;
    @(negedge clk);
    idle();
    rob_alloc_id = 4'd15;
    @(negedge clk);
    chk("rd0_rob_push",  64'(bus.rob_push),  64'd1);
    chk("rd0_rename_en", 64'(bus.rename_en), 64'd0);

    // rdy low with an entry at the head: nothing issues, outputs hold
    drive(32'h8000, 1'b0, 5'd3, 5'd1, 5'd2);
    expect_issue(32'h8000, 1'b0, 5'd3, 4'd2, '0, 32'h100, '0, 32'h200);
    @(negedge clk);
    idle();
    rdy = 1'b0;
    rob_alloc_id = 4'd1;
    @(negedge clk);
    chk("rdy_hold_push", 64'(bus.rob_push), 64'd0);
    chk("rdy_hold_pc",   64'(bus.out_pc),   64'h7000);
    rdy = 1'b1;
    rob_alloc_id = 4'd2;
    @(negedge clk);
    @(negedge clk);

    // reset mid-operation with an entry queued
    rs_full = 1'b1;
    drive(32'h9000, 1'b0, 5'd4, 5'd1, 5'd2);
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rs_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_push",  64'(bus.rob_push), 64'd0);
    chk("midrst_pc",    64'(bus.out_pc),   64'd0);
    chk("midrst_ready", 64'(bus.fet_ready), 64'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
